// File: rtl/nn_layer_mac_counter_act.sv
// MAC-completion counter with sticky done and a combinational
// fixed-point activation for one neuron of a fully-connected layer.
module nn_layer_mac_counter_act #(
  parameter int N_INPUTS  = 2,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  parameter int ACT       = 0,
  localparam int CW = $clog2(N_INPUTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ack,
  output logic                     ack_mac,
  output logic [CW-1:0]            count,
  input  logic signed [DATA_W-1:0] z_value,
  output logic signed [DATA_W-1:0] a
);

  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);
  localparam logic signed [DATA_W:0] ONE =
    (DATA_W+1)'(1 << FRAC_BITS);
  localparam logic signed [DATA_W:0] HALF =
    (DATA_W+1)'(1 << (FRAC_BITS - 1));

  logic [CW-1:0] r_count;
  logic          r_ack_mac;

  // Acks after completion are dropped so count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_ack_mac <= 1'b0;
    end else if (ack && !r_ack_mac) begin
      r_count <= r_count + CW'(1);
      if (r_count == LAST)
        r_ack_mac <= 1'b1;
    end
  end

  assign count   = r_count;
  assign ack_mac = r_ack_mac;

  logic signed [DATA_W-1:0] w_shift;
  logic signed [DATA_W:0]   w_sum;
  logic signed [DATA_W-1:0] w_hsig;

  assign w_shift = z_value >>> 2;
  assign w_sum   = {w_shift[DATA_W-1], w_shift} + HALF;

  always_comb begin
    w_hsig = w_sum[DATA_W-1:0];
    if (w_sum < 0)
      w_hsig = '0;
    else if (w_sum > ONE)
      w_hsig = ONE[DATA_W-1:0];
  end

  always_comb begin
    a = z_value;
    case (ACT)
      0: a = z_value[DATA_W-1] ? '0 : z_value;
      1: a = w_hsig;
      default: a = z_value;
    endcase
  end

endmodule

// File: tb/tb_nn_layer_mac_counter_act.sv
// Scoreboard bench: counter sequences plus ReLU, hard-sigmoid
// and identity activation vectors.
module tb_nn_layer_mac_counter_act;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ack = 1'b0;
  logic signed [7:0] z0 = '0;
  logic signed [7:0] z1 = '0;
  logic signed [7:0] z2 = '0;
  logic signed [7:0] a0, a1, a2;
  logic [1:0] cnt0, cnt1, cnt2;
  logic done0, done1, done2;

  int checks = 0;
  int failures = 0;
  int q_cnt[$];
  int q_done[$];
  int q_a[$];

  always #5 clk = ~clk;

  nn_layer_mac_counter_act #(.N_INPUTS(2), .ACT(0)) u_relu (
    .clk(clk), .rst(rst), .ack(ack), .ack_mac(done0),
    .count(cnt0), .z_value(z0), .a(a0));

  nn_layer_mac_counter_act #(.N_INPUTS(2), .ACT(1)) u_hsig (
    .clk(clk), .rst(rst), .ack(ack), .ack_mac(done1),
    .count(cnt1), .z_value(z1), .a(a1));

  nn_layer_mac_counter_act #(.N_INPUTS(2), .ACT(2)) u_id (
    .clk(clk), .rst(rst), .ack(ack), .ack_mac(done2),
    .count(cnt2), .z_value(z2), .a(a2));

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic i_ack, input logic i_rst,
                      input int e_cnt, input int e_done,
                      input string tag);
    int ec, ed;
    @(negedge clk);
    ack = i_ack;
    rst = i_rst;
    q_cnt.push_back(e_cnt);
    q_done.push_back(e_done);
    @(posedge clk);
    #1;
    ec = q_cnt.pop_front();
    ed = q_done.pop_front();
    chk({tag, "_cnt"}, int'(cnt0), ec);
    chk({tag, "_done"}, int'(done0), ed);
    chk({tag, "_cnt_b"}, int'(cnt1), ec);
    chk({tag, "_done_b"}, int'(done1), ed);
  endtask

  task automatic act(input int sel, input int z, input int e,
                     input string tag);
    int ea;
    q_a.push_back(e);
    case (sel)
      0: z0 = 8'(z);
      1: z1 = 8'(z);
      default: z2 = 8'(z);
    endcase
    #1;
    ea = q_a.pop_front();
    case (sel)
      0: chk(tag, int'(a0), ea);
      1: chk(tag, int'(a1), ea);
      default: chk(tag, int'(a2), ea);
    endcase
  endtask

  initial begin
    step(0, 1, 0, 0, "rst");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "idle");

    step(0, 1, 0, 0, "rst2");
    step(0, 0, 0, 0, "c1");
    step(0, 0, 0, 0, "c2");
    step(1, 0, 1, 0, "c3");
    step(0, 0, 1, 0, "c4");
    step(0, 0, 1, 0, "c5");
    step(1, 0, 2, 1, "c6");
    for (int i = 7; i <= 20; i++) step(0, 0, 2, 1, "hold");
    step(1, 0, 2, 1, "sticky_ack");
    step(1, 0, 2, 1, "sticky_ack2");

    step(0, 1, 0, 0, "rst3");
    step(1, 0, 1, 0, "b2b1");
    step(1, 0, 2, 1, "b2b2");
    step(1, 0, 2, 1, "b2b3");
    step(1, 0, 2, 1, "b2b4");
    step(0, 0, 2, 1, "b2b_idle");

    step(0, 1, 0, 0, "rst4");
    step(1, 0, 1, 0, "mid1");
    step(1, 1, 0, 0, "mid_rst");
    step(0, 0, 0, 0, "mid_idle");
    step(1, 0, 1, 0, "mid2");
    step(0, 0, 1, 0, "mid3");
    step(1, 0, 2, 1, "mid4");

    rst = 1'b1;
    act(0, -79, 0, "relu_n79");
    act(0, 0, 0, "relu_0");
    act(0, 37, 37, "relu_37");
    act(0, 127, 127, "relu_127");
    act(0, -1, 0, "relu_n1");
    act(1, -128, 0, "hs_n128");
    act(1, -32, 0, "hs_n32");
    act(1, 0, 8, "hs_0");
    act(1, 20, 13, "hs_20");
    act(1, 40, 16, "hs_40");
    act(1, 127, 16, "hs_127");
    act(1, -5, 6, "hs_n5");
    act(1, 32, 16, "hs_32");
    act(2, -100, -100, "id_n100");
    act(2, 55, 55, "id_55");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
